// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// No logic; no latency.
// No flow control of its own.
package inst_prefetch_pkg;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic [31:0] INST_WORD_INC = 32'd4;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + INST_WORD_INC;
    endfunction

endpackage

// File: rtl/inst_prefetch_fetch_fifo.sv
// Synchronous FIFO of {addr, inst} entries with combinational head and flush.
// Push visible at head one cycle after the write edge.
// No internal backpressure: the caller never pushes when full or pops when empty.
module inst_prefetch_fetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [$bits(fetch_entry_t)-1:0] push_dat,
    input  logic                             pop,
    input  logic                             flush,
    output logic [AW:0]                      count,
    output logic [$bits(fetch_entry_t)-1:0] head_dat
);

    logic [$bits(fetch_entry_t)-1:0] store [DEPTH];
    logic [AW-1:0]                   rd_ptr;
    logic [AW-1:0]                   wr_ptr;

    // Flush wins over a same-cycle push; the pushed word belongs to the old stream.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            store[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = store[rd_ptr];

endmodule

// File: rtl/inst_prefetch.sv
// Prefetch buffer between the core ROM port and a req/ack instruction memory.
// Hit served combinationally; redirect to first hit is 2 cycles with a zero-wait memory.
// Stalls the core on miss; stops requesting while buffered plus outstanding words fill DEPTH.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    mem_state_e   state;
    logic [31:0]  pf_addr;
    logic         discard;

    logic [AW:0]  count;
    logic [AW:0]  count_next;
    fetch_entry_t head;
    fetch_entry_t push_dat;
    logic [31:0]  exp_addr;
    logic         hit;
    logic         redirect;
    logic         pop;
    logic         ack;
    logic         push;
    logic         space_ok;

    always_comb begin
        exp_addr = pf_addr;
        if (count != '0) begin
            exp_addr = head.addr;
        end else if (state == MEM_WAIT && !discard) begin
            exp_addr = mem_addr_o;
        end

        hit      = rom_ce_i && (count != '0) && (head.addr == rom_addr_i);
        redirect = rom_ce_i && (rom_addr_i != exp_addr);
        pop      = hit && !stall_i;
        ack      = (state == MEM_WAIT) && mem_ack_i;
        push     = ack && !discard && !redirect;

        // The outstanding request already counts against capacity, so push never meets full.
        count_next = count - {{AW{1'b0}}, pop} + {{AW{1'b0}}, push};
        space_ok   = count_next < DEPTH_CNT;

        push_dat.addr = mem_addr_o;
        push_dat.inst = mem_rdata_i;

        inst_o     = hit ? head.inst : ZERO_WORD;
        stallreq_o = rom_ce_i && !hit;
    end

    inst_prefetch_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect),
        .count    (count),
        .head_dat (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state      <= MEM_IDLE;
            pf_addr    <= RESET_ADDR;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            discard    <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (redirect) begin
                        pf_addr <= rom_addr_i;
                    end else if (space_ok) begin
                        state      <= MEM_WAIT;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pf_addr;
                        pf_addr    <= next_word_addr(pf_addr);
                    end
                end
                MEM_WAIT: begin
                    if (redirect) begin
                        pf_addr <= rom_addr_i;
                    end
                    if (ack) begin
                        discard <= 1'b0;
                        if (!redirect && space_ok) begin
                            mem_addr_o <= pf_addr;
                            pf_addr    <= next_word_addr(pf_addr);
                        end else begin
                            state     <= MEM_IDLE;
                            mem_req_o <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request cannot be withdrawn; its data is dropped when it lands.
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: a core model walking a PC and a memory model with
// random wait states; the buffer must behave as a transparent instruction cache.
module tb_inst_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic        stall_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    inst_prefetch #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .stall_i     (stall_i),
        .inst_o      (inst_o),
        .stallreq_o  (stallreq_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Core / memory model state
    logic [31:0] pc;
    bit          adv_prev;
    bit          in_prog;
    bit          txn_stale;
    logic [31:0] txn_addr;
    int          wait_cnt;
    int          wait_min;
    int          wait_max;
    bit          expect_hit;
    logic [31:0] expect_addr;
    int          stall_run;
    bit          force_jump;
    logic [31:0] force_target;
    logic [31:0] pend_q[$];
    logic [31:0] exp_txn_q[$];
    int          p_jump;
    int          p_stall;
    int          p_ceoff;
    bit          hold_stall;
    logic        obs_stallreq;
    logic        obs_req;
    logic [31:0] obs_inst;

    task automatic reset_model();
        pc         = 32'h0;
        adv_prev   = 1'b0;
        in_prog    = 1'b0;
        txn_stale  = 1'b0;
        wait_cnt   = 0;
        expect_hit = 1'b0;
        stall_run  = 0;
        force_jump = 1'b0;
        pend_q.delete();
        exp_txn_q.delete();
    endtask

    // One core clock cycle, entered and left at a falling edge.
    task automatic step();
        logic [31:0] d;
        bit          jumped;
        if (in_prog) begin
            check("req_hold", 32'(mem_req_o), 32'd1);
            check("addr_stable", mem_addr_o, txn_addr);
            if (!mem_req_o) in_prog = 1'b0;
        end else if (mem_req_o) begin
            in_prog   = 1'b1;
            txn_stale = 1'b0;
            txn_addr  = mem_addr_o;
            wait_cnt  = int'($urandom_range(wait_max, wait_min));
            if (exp_txn_q.size() > 0) check("txn_addr", mem_addr_o, exp_txn_q.pop_front());
        end
        mem_ack_i   = in_prog && (wait_cnt == 0);
        mem_rdata_i = mem_ack_i ? word_of(txn_addr) : 32'hDEAD_BEEF;

        jumped = 1'b0;
        if (adv_prev) begin
            if (force_jump) begin
                pc         = force_target;
                force_jump = 1'b0;
                jumped     = 1'b1;
                exp_txn_q  = pend_q;
                pend_q.delete();
            end else if (int'($urandom_range(99)) < p_jump) begin
                pc     = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                                  : ($urandom & 32'h0000_0FFC);
                jumped = 1'b1;
            end else begin
                pc = pc + 32'd4;
            end
            if (jumped && in_prog) txn_stale = 1'b1;
        end
        rom_ce_i   = int'($urandom_range(99)) >= p_ceoff;
        stall_i    = hold_stall || (int'($urandom_range(99)) < p_stall);
        rom_addr_i = pc;

        #1;
        obs_stallreq = stallreq_o;
        obs_req      = mem_req_o;
        obs_inst     = inst_o;
        if (!rom_ce_i) begin
            check("idle_inst", inst_o, 32'h0);
            check("idle_stallreq", 32'(stallreq_o), 32'd0);
        end else if (stallreq_o) begin
            check("miss_inst", inst_o, 32'h0);
        end else begin
            check("hit_data", inst_o, word_of(pc));
            if (mem_req_o) begin
                // Buffered words plus the outstanding one never exceed DEPTH.
                d = mem_addr_o - pc;
                check("pf_dist", 32'(d >= 32'd4 && d <= 32'(4 * (DEPTH - 1))), 32'd1);
            end
        end
        if (expect_hit) begin
            if (rom_ce_i && pc == expect_addr) check("ack_to_hit", 32'(stallreq_o), 32'd0);
            expect_hit = 1'b0;
        end
        if (rom_ce_i && stallreq_o) stall_run++;
        else stall_run = 0;
        if (stall_run == 40) begin
            check("stall_bound", 32'(stall_run), 32'd0);
            stall_run = 0;
        end

        @(posedge clk);
        if (mem_ack_i) begin
            in_prog = 1'b0;
            if (!txn_stale && pc == txn_addr) begin
                expect_hit  = 1'b1;
                expect_addr = txn_addr;
            end
        end else if (in_prog) begin
            wait_cnt--;
        end
        adv_prev = rom_ce_i && !obs_stallreq && !stall_i;
        @(negedge clk);
    endtask

    logic [31:0] held;

    initial begin
        rst        = 1'b0;
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'h0;
        stall_i    = 1'b0;
        mem_ack_i  = 1'b0;
        mem_rdata_i = 32'h0;
        wait_min   = 0;
        wait_max   = 0;
        p_jump     = 0;
        p_stall    = 0;
        p_ceoff    = 0;
        hold_stall = 1'b0;
        force_target = 32'h0;
        reset_model();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);

        // Zero-wait startup: two miss cycles, then one hit per cycle
        rst = 1'b1;
        exp_txn_q.push_back(32'h0);
        for (int c = 0; c < 12; c++) begin
            step();
            check("t1_stallreq", 32'(obs_stallreq), 32'(c < 2));
            if (c >= 1) check("t1_req", 32'(obs_req), 32'd1);
        end

        // Three wait states
        wait_min = 3;
        wait_max = 3;
        repeat (30) step();

        // Fill the buffer under stall, then redirect mid-request
        hold_stall = 1'b1;
        repeat (30) step();
        check("t3_full_req", 32'(obs_req), 32'd0);
        hold_stall   = 1'b0;
        force_jump   = 1'b1;
        force_target = 32'h0000_0100;
        pend_q.push_back(32'h0000_0100);
        pend_q.push_back(32'h0000_0104);
        repeat (25) step();
        check("t3_redirect_seen", 32'(exp_txn_q.size() + pend_q.size()), 32'd0);

        // Stall for 5 cycles during a zero-wait stream
        wait_min = 0;
        wait_max = 0;
        repeat (10) step();
        hold_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) held = obs_inst;
            check("t4_hold_hit", 32'(obs_stallreq), 32'd0);
            check("t4_hold_inst", obs_inst, held);
        end
        check("t4_full_req_low", 32'(obs_req), 32'd0);
        hold_stall = 1'b0;
        repeat (15) step();

        // Address wrap
        force_jump   = 1'b1;
        force_target = 32'hFFFF_FFF8;
        pend_q.push_back(32'hFFFF_FFF8);
        pend_q.push_back(32'hFFFF_FFFC);
        pend_q.push_back(32'h0000_0000);
        repeat (12) step();
        check("t5_wrap_seen", 32'(exp_txn_q.size() + pend_q.size()), 32'd0);

        // Asynchronous reset while a request is outstanding
        wait_min = 3;
        wait_max = 3;
        for (int i = 0; i < 10 && !mem_req_o; i++) step();
        check("t6_req_before", 32'(mem_req_o), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("t6_req_cleared", 32'(mem_req_o), 32'd0);
        check("t6_addr_cleared", mem_addr_o, 32'h0);
        rom_ce_i = 1'b0;
        #1;
        check("t6_inst", inst_o, 32'h0);
        check("t6_stallreq", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        reset_model();
        exp_txn_q.push_back(32'h0);
        rst = 1'b1;
        repeat (20) step();
        check("t6_first_req", 32'(exp_txn_q.size()), 32'd0);

        // Randomized traffic
        wait_min = 0;
        wait_max = 3;
        p_jump   = 10;
        p_stall  = 15;
        p_ceoff  = 10;
        repeat (1500) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
